// File: rtl/change_dispenser_if.sv
// Request/payout bus of the change dispenser: request handshake in, coin pulses and status out.
interface change_dispenser_if #(
    parameter int AMT_W = 8
);
    logic             req_valid;
    logic [AMT_W-1:0] req_amount;
    logic             req_ready;
    logic             coin10;
    logic             coin5;
    logic             coin1;
    logic             busy;
    logic             done;
    logic [AMT_W-1:0] remaining;

    modport master (
        output req_valid, req_amount,
        input  req_ready, coin10, coin5, coin1, busy, done, remaining
    );

    modport slave (
        input  req_valid, req_amount,
        output req_ready, coin10, coin5, coin1, busy, done, remaining
    );
endinterface

// File: rtl/change_dispenser.sv
// Greedy coin payout (10/5/1) with one idle cycle between coin pulses.
// Optional finite coin inventory with refill/short: `define CHANGE_DISPENSER_INVENTORY_EN.
module change_dispenser #(
    parameter int AMT_W = 8,
    parameter int INV_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    change_dispenser_if.slave bus
`ifdef CHANGE_DISPENSER_INVENTORY_EN
    ,
    input  logic              refill,
    output logic              short
`endif
);

    typedef enum logic [1:0] {IDLE, PAY, GAP, DONE} state_t;

    localparam logic [AMT_W-1:0] TEN  = AMT_W'(10);
    localparam logic [AMT_W-1:0] FIVE = AMT_W'(5);
    localparam logic [AMT_W-1:0] ONE  = AMT_W'(1);

    state_t           state_q, state_d;
    logic [AMT_W-1:0] remaining_q, remaining_d;
    logic             coin10_q, coin10_d;
    logic             coin5_q, coin5_d;
    logic             coin1_q, coin1_d;
    logic             load;
    logic [AMT_W-1:0] src;

`ifdef CHANGE_DISPENSER_INVENTORY_EN
    logic [INV_W-1:0] cnt10_q, cnt10_d;
    logic [INV_W-1:0] cnt5_q, cnt5_d;
    logic [INV_W-1:0] cnt1_q, cnt1_d;
    logic             stall_q, stall_d;
    logic             short_q, short_d;
`endif

    // The coin for a PAY cycle is chosen on the edge entering PAY so the
    // pulse and the post-decrement remaining are both registered together.
    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        coin10_d    = 1'b0;
        coin5_d     = 1'b0;
        coin1_d     = 1'b0;
        load        = 1'b0;
        src         = remaining_q;
`ifdef CHANGE_DISPENSER_INVENTORY_EN
        cnt10_d     = cnt10_q;
        cnt5_d      = cnt5_q;
        cnt1_d      = cnt1_q;
        stall_d     = 1'b0;
        short_d     = 1'b0;
`endif

        case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    remaining_d = bus.req_amount;
                    if (bus.req_amount == '0) begin
                        state_d = DONE;
                    end else begin
                        load = 1'b1;
                        src  = bus.req_amount;
                    end
                end
            end
            PAY: begin
`ifdef CHANGE_DISPENSER_INVENTORY_EN
                short_d = stall_q;
                state_d = (stall_q || remaining_q == '0) ? DONE : GAP;
`else
                state_d = (remaining_q == '0) ? DONE : GAP;
`endif
            end
            GAP:     load    = 1'b1;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (load) begin
            state_d = PAY;
`ifdef CHANGE_DISPENSER_INVENTORY_EN
            // Empty denominations are skipped; with nothing usable the PAY
            // cycle carries no coin and ends the payout as short.
            if (src >= TEN && cnt10_q != '0) begin
                coin10_d    = 1'b1;
                remaining_d = src - TEN;
                cnt10_d     = cnt10_q - INV_W'(1);
            end else if (src >= FIVE && cnt5_q != '0) begin
                coin5_d     = 1'b1;
                remaining_d = src - FIVE;
                cnt5_d      = cnt5_q - INV_W'(1);
            end else if (cnt1_q != '0) begin
                coin1_d     = 1'b1;
                remaining_d = src - ONE;
                cnt1_d      = cnt1_q - INV_W'(1);
            end else begin
                stall_d     = 1'b1;
                remaining_d = src;
            end
`else
            if (src >= TEN) begin
                coin10_d    = 1'b1;
                remaining_d = src - TEN;
            end else if (src >= FIVE) begin
                coin5_d     = 1'b1;
                remaining_d = src - FIVE;
            end else begin
                coin1_d     = 1'b1;
                remaining_d = src - ONE;
            end
`endif
        end

`ifdef CHANGE_DISPENSER_INVENTORY_EN
        if (refill) begin
            cnt10_d = '1;
            cnt5_d  = '1;
            cnt1_d  = '1;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            remaining_q <= '0;
            coin10_q    <= 1'b0;
            coin5_q     <= 1'b0;
            coin1_q     <= 1'b0;
`ifdef CHANGE_DISPENSER_INVENTORY_EN
            cnt10_q     <= '1;
            cnt5_q      <= '1;
            cnt1_q      <= '1;
            stall_q     <= 1'b0;
            short_q     <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            coin10_q    <= coin10_d;
            coin5_q     <= coin5_d;
            coin1_q     <= coin1_d;
`ifdef CHANGE_DISPENSER_INVENTORY_EN
            cnt10_q     <= cnt10_d;
            cnt5_q      <= cnt5_d;
            cnt1_q      <= cnt1_d;
            stall_q     <= stall_d;
            short_q     <= short_d;
`endif
        end
    end

    assign bus.req_ready = (state_q == IDLE);
    assign bus.busy      = (state_q != IDLE);
    assign bus.done      = (state_q == DONE);
    assign bus.coin10    = coin10_q;
    assign bus.coin5     = coin5_q;
    assign bus.coin1     = coin1_q;
    assign bus.remaining = remaining_q;
`ifdef CHANGE_DISPENSER_INVENTORY_EN
    assign short         = short_q;
`endif

endmodule

// File: tb/tb_change_dispenser.sv
// Self-checking bench for change_dispenser: directed and random payouts against a greedy coin model.
module tb_change_dispenser;

    localparam int AMT_W = 8;
`ifdef CHANGE_DISPENSER_INVENTORY_EN
    localparam int INV_W   = 2;
    localparam int INV_MAX = 3;
`else
    localparam int INV_MAX = 1 << 30;
`endif

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   checks   = 0;
    int   failures = 0;
    int   cnt[3];   // model inventory: [0]=coin10, [1]=coin5, [2]=coin1

    always #5 clk = ~clk;

    change_dispenser_if #(.AMT_W(AMT_W)) bus ();

`ifdef CHANGE_DISPENSER_INVENTORY_EN
    logic refill = 1'b0;
    logic short;
    change_dispenser #(.AMT_W(AMT_W), .INV_W(INV_W)) dut (
        .clk(clk), .reset(reset), .bus(bus), .refill(refill), .short(short)
    );
`else
    change_dispenser #(.AMT_W(AMT_W)) dut (
        .clk(clk), .reset(reset), .bus(bus)
    );
`endif

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "bench timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic logic [2:0] coins();
        return {bus.coin10, bus.coin5, bus.coin1};
    endfunction

    task automatic model_refill();
        for (int i = 0; i < 3; i++) cnt[i] = INV_MAX;
    endtask

    task automatic check_idle(input string tag);
        chk({tag, "_ready"}, bus.req_ready, 1);
        chk({tag, "_busy"}, bus.busy, 0);
        chk({tag, "_done"}, bus.done, 0);
        chk({tag, "_coins"}, coins(), 0);
        chk({tag, "_rem"}, bus.remaining, 0);
`ifdef CHANGE_DISPENSER_INVENTORY_EN
        chk({tag, "_short"}, short, 0);
`endif
    endtask

    // Called at a falling edge with the dispenser idle; returns at the falling
    // edge of the first ready cycle after done.
    task automatic pay(input int a, input bit keep_valid, input int refill_k);
        int q[$];
        int rem;
        int n;
        int done_cyc;
        int c;
        bit sh;
        logic [2:0] ec;

        rem = a;
        sh  = 1'b0;
        while (rem > 0) begin
            if (rem >= 10 && cnt[0] > 0) begin
                q.push_back(10); cnt[0]--; rem -= 10;
            end else if (rem >= 5 && cnt[1] > 0) begin
                q.push_back(5); cnt[1]--; rem -= 5;
            end else if (cnt[2] > 0) begin
                q.push_back(1); cnt[2]--; rem -= 1;
            end else begin
                sh = 1'b1;
                break;
            end
        end
        n = q.size();
        done_cyc = sh ? 2 * n + 2 : (n == 0 ? 1 : 2 * n);

        chk($sformatf("ready_before_a%0d", a), bus.req_ready, 1);
        bus.req_valid  = 1'b1;
        bus.req_amount = AMT_W'(a);
        @(posedge clk);
        @(negedge clk);
        if (!keep_valid) bus.req_valid = 1'b0;

        rem = a;
        for (int k = 1; k <= done_cyc + 1; k++) begin
            ec = '0;
            if (k % 2 == 1 && (k + 1) / 2 <= n) begin
                c   = q[(k - 1) / 2];
                rem -= c;
                ec  = (c == 10) ? 3'b100 : (c == 5) ? 3'b010 : 3'b001;
            end
            chk($sformatf("coins_a%0d_c%0d", a, k), coins(), ec);
            chk($sformatf("rem_a%0d_c%0d", a, k), bus.remaining, rem);
            chk($sformatf("done_a%0d_c%0d", a, k), bus.done, k == done_cyc);
            chk($sformatf("busy_a%0d_c%0d", a, k), bus.busy, k <= done_cyc);
            chk($sformatf("ready_a%0d_c%0d", a, k), bus.req_ready, k == done_cyc + 1);
`ifdef CHANGE_DISPENSER_INVENTORY_EN
            chk($sformatf("short_a%0d_c%0d", a, k), short, sh && k == done_cyc);
            refill = (k == refill_k);
`endif
            if (k <= done_cyc) @(negedge clk);
        end
`ifdef CHANGE_DISPENSER_INVENTORY_EN
        refill = 1'b0;
        if (refill_k > 0) model_refill();
`endif
    endtask

    initial begin
        bus.req_valid  = 1'b0;
        bus.req_amount = '0;
        model_refill();

        // Reset state; a request held during reset must be ignored.
        bus.req_valid  = 1'b1;
        bus.req_amount = AMT_W'(12);
        repeat (2) @(negedge clk);
        check_idle("reset");
        bus.req_valid = 1'b0;
        reset = 1'b0;
        @(negedge clk);
        check_idle("after_reset");

        pay(27, 1'b0, 0);
        pay(0, 1'b0, 0);

        // req_valid held through a payout: the second request waits for done.
        pay(15, 1'b1, 0);
        pay(15, 1'b0, 0);

        // Reset after the 2nd coin of 30 aborts the payout.
        bus.req_valid  = 1'b1;
        bus.req_amount = AMT_W'(30);
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 1'b0;
        chk("abort_c1_coins", coins(), 3'b100);
        chk("abort_c1_rem", bus.remaining, 20);
        @(negedge clk);
        chk("abort_c2_coins", coins(), 3'b000);
        @(negedge clk);
        chk("abort_c3_coins", coins(), 3'b100);
        chk("abort_c3_rem", bus.remaining, 10);
        reset          = 1'b1;
        bus.req_valid  = 1'b1;
        bus.req_amount = AMT_W'(5);
        @(negedge clk);
        check_idle("abort_reset1");
        reset         = 1'b0;
        bus.req_valid = 1'b0;
        @(negedge clk);
        check_idle("abort_reset2");
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_idle($sformatf("abort_quiet%0d", i));
        end
        model_refill();

        // Boundaries around the denominations and the width limit.
        pay(1, 1'b0, 0);
        pay(4, 1'b0, 0);
        pay(5, 1'b0, 0);
        pay(9, 1'b0, 0);
        pay(10, 1'b0, 0);
        pay(255, 1'b0, 0);

        for (int i = 0; i < 16; i++) begin
            pay(int'($urandom_range(0, 63)), 1'b0, 0);
        end

`ifdef CHANGE_DISPENSER_INVENTORY_EN
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        model_refill();
        @(negedge clk);
        check_idle("inv_reset");

        pay(10, 1'b0, 0);
        pay(10, 1'b0, 0);
        pay(10, 1'b0, 0);
        pay(10, 1'b0, 0);   // coin10 exhausted: 5,5
        pay(10, 1'b0, 0);   // 5,1,1,1 then short with 2 left
        pay(7, 1'b0, 0);    // nothing left: short immediately

        refill = 1'b1;
        @(negedge clk);
        refill = 1'b0;
        model_refill();

        pay(10, 1'b0, 1);   // refill lands on the coin10 pulse cycle
        pay(30, 1'b0, 0);   // three coin10s only if the count read back as 3
        pay(10, 1'b0, 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
